// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding select and load-use stall control for a pipeline with an
// EX slot followed by FWD_DEPTH writeback-tracking stages (S1 nearest).
module forwarding_hazard_unit #(
    parameter int REG_ADDR_SIZE = 5,
    parameter int FWD_DEPTH     = 2,
    parameter int LOAD_LATENCY  = 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_halt,
    input  logic                     i_flush,
    input  logic                     i_id_valid,
    input  logic                     i_id_wb,
    input  logic                     i_id_mem_read,
    input  logic [REG_ADDR_SIZE-1:0] i_id_rs,
    input  logic [REG_ADDR_SIZE-1:0] i_id_rt,
    input  logic [REG_ADDR_SIZE-1:0] i_id_wb_addr,
    output logic                     o_stall,
    output logic [1:0]               o_sc_data_a_src,
    output logic [1:0]               o_sc_data_b_src
);

    typedef enum logic {RUN, STALL} state_t;

    localparam logic [1:0] CNT_LOAD = 2'(LOAD_LATENCY - 1);

    state_t                   state_reg, state_next;
    logic [1:0]               cnt_reg, cnt_next;
    logic                     stall;
    logic                     hazard;
    logic                     bubble;

    logic                     ex_valid_reg;
    logic                     ex_wb_reg;
    logic                     ex_mem_read_reg;
    logic [REG_ADDR_SIZE-1:0] ex_rs_reg;
    logic [REG_ADDR_SIZE-1:0] ex_rt_reg;
    logic [REG_ADDR_SIZE-1:0] ex_wb_addr_reg;

    logic                     s_wb_reg      [FWD_DEPTH];
    logic [REG_ADDR_SIZE-1:0] s_wb_addr_reg [FWD_DEPTH];

    assign bubble = i_flush | stall;

    // Addresses follow ID even on a bubble; the cleared control bits make them inert.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ex_valid_reg    <= 1'b0;
            ex_wb_reg       <= 1'b0;
            ex_mem_read_reg <= 1'b0;
            ex_rs_reg       <= '0;
            ex_rt_reg       <= '0;
            ex_wb_addr_reg  <= '0;
        end else if (!i_halt) begin
            ex_valid_reg    <= bubble ? 1'b0 : i_id_valid;
            ex_wb_reg       <= bubble ? 1'b0 : i_id_wb;
            ex_mem_read_reg <= bubble ? 1'b0 : i_id_mem_read;
            ex_rs_reg       <= i_id_rs;
            ex_rt_reg       <= i_id_rt;
            ex_wb_addr_reg  <= i_id_wb_addr;
        end
    end

    generate
        for (genvar gi = 0; gi < FWD_DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge i_clk) begin
                    if (i_reset) begin
                        s_wb_reg[gi]      <= 1'b0;
                        s_wb_addr_reg[gi] <= '0;
                    end else if (!i_halt) begin
                        s_wb_reg[gi]      <= ex_wb_reg;
                        s_wb_addr_reg[gi] <= ex_wb_addr_reg;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge i_clk) begin
                    if (i_reset) begin
                        s_wb_reg[gi]      <= 1'b0;
                        s_wb_addr_reg[gi] <= '0;
                    end else if (!i_halt) begin
                        s_wb_reg[gi]      <= s_wb_reg[gi-1];
                        s_wb_addr_reg[gi] <= s_wb_addr_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Scan farthest to nearest so the youngest matching producer overrides.
    always_comb begin
        o_sc_data_a_src = 2'b00;
        o_sc_data_b_src = 2'b00;
        for (int j = FWD_DEPTH - 1; j >= 0; j--) begin
            if (s_wb_reg[j] && (s_wb_addr_reg[j] == ex_rs_reg))
                o_sc_data_a_src = 2'(FWD_DEPTH - j);
            if (s_wb_reg[j] && (s_wb_addr_reg[j] == ex_rt_reg))
                o_sc_data_b_src = 2'(FWD_DEPTH - j);
        end
        if (!ex_valid_reg || (ex_rs_reg == '0))
            o_sc_data_a_src = 2'b00;
        if (!ex_valid_reg || (ex_rt_reg == '0))
            o_sc_data_b_src = 2'b00;
    end

    assign hazard = i_id_valid & ex_valid_reg & ex_mem_read_reg & ex_wb_reg &
                    (ex_wb_addr_reg != '0) &
                    ((ex_wb_addr_reg == i_id_rs) | (ex_wb_addr_reg == i_id_rt));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall      = 1'b0;
        case (state_reg)
            RUN: begin
                stall = hazard & ~i_flush;
                if (stall && (LOAD_LATENCY > 1)) begin
                    state_next = STALL;
                    cnt_next   = CNT_LOAD;
                end
            end
            STALL: begin
                stall    = ~i_flush;
                cnt_next = cnt_reg - 2'd1;
                if (cnt_reg == 2'd1)
                    state_next = RUN;
            end
            default: begin
                state_next = RUN;
                cnt_next   = 2'd0;
            end
        endcase
        if (i_flush) begin
            state_next = RUN;
            cnt_next   = 2'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg <= RUN;
            cnt_reg   <= 2'd0;
        end else if (!i_halt) begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign o_stall = stall;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench: three instances (LOAD_LATENCY 1, 2, 3) share one stimulus
// stream; each scenario starts from reset and checks the instance it targets.
module tb_forwarding_hazard_unit;

    logic       clk = 1'b0;
    logic       rst, halt, flush;
    logic       id_valid, id_wb, id_mem_read;
    logic [4:0] id_rs, id_rt, id_wb_addr;

    logic       stall1, stall2, stall3;
    logic [1:0] a1, b1, a2, b2, a3, b3;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    forwarding_hazard_unit #(.REG_ADDR_SIZE(5), .FWD_DEPTH(2), .LOAD_LATENCY(1)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_halt(halt), .i_flush(flush),
        .i_id_valid(id_valid), .i_id_wb(id_wb), .i_id_mem_read(id_mem_read),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_wb_addr(id_wb_addr),
        .o_stall(stall1), .o_sc_data_a_src(a1), .o_sc_data_b_src(b1));

    forwarding_hazard_unit #(.REG_ADDR_SIZE(5), .FWD_DEPTH(2), .LOAD_LATENCY(2)) dut2 (
        .i_clk(clk), .i_reset(rst), .i_halt(halt), .i_flush(flush),
        .i_id_valid(id_valid), .i_id_wb(id_wb), .i_id_mem_read(id_mem_read),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_wb_addr(id_wb_addr),
        .o_stall(stall2), .o_sc_data_a_src(a2), .o_sc_data_b_src(b2));

    forwarding_hazard_unit #(.REG_ADDR_SIZE(5), .FWD_DEPTH(2), .LOAD_LATENCY(3)) dut3 (
        .i_clk(clk), .i_reset(rst), .i_halt(halt), .i_flush(flush),
        .i_id_valid(id_valid), .i_id_wb(id_wb), .i_id_mem_read(id_mem_read),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_wb_addr(id_wb_addr),
        .o_stall(stall3), .o_sc_data_a_src(a3), .o_sc_data_b_src(b3));

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) begin
            $display("ok   %-22s observed=%0d expected=%0d", tag, obs, exp);
        end else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) begin
            $display("ok   %-22s observed=%0d expected=%0d", tag, obs, exp);
        end else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic wb, input logic mr,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wd);
        id_valid    = v;
        id_wb       = wb;
        id_mem_read = mr;
        id_rs       = rs;
        id_rt       = rt;
        id_wb_addr  = wd;
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        halt  = 1'b0;
        flush = 1'b0;
        set_id(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0; flush = 1'b0;
        set_id(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        chk1("reset_stall", stall1, 1'b0);
        chk2("reset_a_src", a1, 2'b00);
        chk2("reset_b_src", b3, 2'b00);

        // ALU r3 forwarded from S1 then S2
        do_reset();
        set_id(1, 1, 0, 5'd1, 5'd2, 5'd3); tick();
        set_id(1, 1, 0, 5'd3, 5'd7, 5'd8); tick();
        chk2("r3_in_s1_a", a1, 2'b10);
        chk2("r3_in_s1_b", b1, 2'b00);
        set_id(1, 0, 0, 5'd3, 5'd0, 5'd0); tick();
        chk2("r3_in_s2_a", a1, 2'b01);

        // r5 written by both S1 and S2: nearest wins
        do_reset();
        set_id(1, 1, 0, 5'd1, 5'd1, 5'd5); tick();
        set_id(1, 1, 0, 5'd2, 5'd2, 5'd5); tick();
        set_id(1, 0, 0, 5'd6, 5'd5, 5'd0); tick();
        chk2("r5_both_b", b1, 2'b10);
        chk2("r5_both_a", a1, 2'b00);
        do_reset();
        set_id(1, 1, 0, 5'd1, 5'd1, 5'd5); tick();
        set_id(1, 0, 0, 5'd2, 5'd2, 5'd5); tick();
        set_id(1, 0, 0, 5'd6, 5'd5, 5'd0); tick();
        chk2("r5_s1_nowb_b", b1, 2'b01);

        // r0 is never forwarded; invalid EX never forwards
        do_reset();
        set_id(1, 1, 0, 5'd1, 5'd1, 5'd0); tick();
        set_id(1, 0, 0, 5'd0, 5'd0, 5'd9); tick();
        chk2("r0_a", a1, 2'b00);
        chk2("r0_b", b1, 2'b00);
        set_id(1, 1, 0, 5'd1, 5'd1, 5'd3); tick();
        set_id(0, 0, 0, 5'd3, 5'd3, 5'd0); tick();
        chk2("ex_invalid_a", a1, 2'b00);

        // load r4 followed by a dependent: stall lengths for all latencies
        do_reset();
        set_id(1, 1, 1, 5'd0, 5'd0, 5'd4); tick();
        set_id(1, 1, 0, 5'd4, 5'd6, 5'd9);
        chk1("lu_c0_stall_ll1", stall1, 1'b1);
        chk1("lu_c0_stall_ll2", stall2, 1'b1);
        chk1("lu_c0_stall_ll3", stall3, 1'b1);
        tick();
        chk1("lu_c1_stall_ll1", stall1, 1'b0);
        chk2("lu_c1_bubble_a_ll1", a1, 2'b00);
        chk1("lu_c1_stall_ll2", stall2, 1'b1);
        chk1("lu_c1_stall_ll3", stall3, 1'b1);
        tick();
        chk2("lu_c2_fwd_a_ll1", a1, 2'b01);
        chk1("lu_c2_stall_ll1", stall1, 1'b0);
        chk1("lu_c2_stall_ll2", stall2, 1'b0);
        chk1("lu_c2_stall_ll3", stall3, 1'b1);
        tick();
        chk1("lu_c3_stall_ll3", stall3, 1'b0);

        // LOAD_LATENCY=3 with a 2-cycle halt in the middle of the stall
        do_reset();
        set_id(1, 1, 1, 5'd0, 5'd0, 5'd4); tick();
        set_id(1, 1, 0, 5'd4, 5'd6, 5'd9);
        chk1("halt_c0_stall", stall3, 1'b1);
        tick();
        halt = 1'b1; #1;
        chk1("halt_c1_stall", stall3, 1'b1);
        tick();
        chk1("halt_c2_stall", stall3, 1'b1);
        tick();
        halt = 1'b0; #1;
        chk1("halt_c3_stall", stall3, 1'b1);
        tick();
        chk1("halt_c4_stall", stall3, 1'b1);
        tick();
        chk1("halt_c5_stall", stall3, 1'b0);
        tick();
        chk2("halt_c6_a", a3, 2'b00);

        // LOAD_LATENCY=2, flush during STALL
        do_reset();
        set_id(1, 1, 1, 5'd0, 5'd0, 5'd4); tick();
        set_id(1, 1, 0, 5'd4, 5'd6, 5'd9);
        chk1("fl_c0_stall", stall2, 1'b1);
        tick();
        flush = 1'b1; #1;
        chk1("fl_c1_stall", stall2, 1'b0);
        tick();
        flush = 1'b0; #1;
        chk1("fl_c2_stall_run", stall2, 1'b0);
        chk2("fl_c2_bubble_a", a2, 2'b00);

        // hazard together with flush in RUN
        do_reset();
        set_id(1, 1, 1, 5'd0, 5'd0, 5'd4); tick();
        set_id(1, 1, 0, 5'd4, 5'd6, 5'd9);
        flush = 1'b1; #1;
        chk1("hzfl_stall_ll1", stall1, 1'b0);
        chk1("hzfl_stall_ll3", stall3, 1'b0);
        tick();
        flush = 1'b0; #1;
        chk1("hzfl_next_stall", stall3, 1'b0);
        chk2("hzfl_bubble_a", a3, 2'b00);
        tick();
        chk2("hzfl_fwd_s2_a", a3, 2'b01);

        // reset (with halt) asserted in STALL
        do_reset();
        set_id(1, 1, 0, 5'd1, 5'd1, 5'd7); tick();
        set_id(1, 1, 1, 5'd7, 5'd0, 5'd4); tick();
        set_id(1, 1, 0, 5'd4, 5'd6, 5'd9);
        chk2("pre_rst_a", a3, 2'b10);
        chk1("pre_rst_stall", stall3, 1'b1);
        tick();
        chk1("pre_rst_c1_stall", stall3, 1'b1);
        rst = 1'b1; halt = 1'b1;
        tick();
        chk1("rst_stall", stall3, 1'b0);
        chk2("rst_a", a3, 2'b00);
        chk2("rst_b", b3, 2'b00);
        rst = 1'b0; halt = 1'b0;
        tick();
        chk1("post_rst_stall", stall3, 1'b0);
        chk2("post_rst_a", a3, 2'b00);
        chk2("post_rst_b", b3, 2'b00);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
